// File: rtl/key_pwm_ctrl.sv
// Per-key PWM solenoid driver: serial (key, velocity) commands set double-buffered duties that drive
// active-low outputs from one shared phase counter. Define KEY_HOLD_REDUCE_EN to enable hold-duty reduction.
module key_pwm_ctrl #(
    parameter int NUM_KEYS     = 12,
    parameter int KEY_BITS     = 7,
    parameter int VEL_BITS     = 7,
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_PERIODS = 64,
    parameter int HOLD_DUTY    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sr_clk,
    input  logic                sr_d,
    input  logic                sr_latch,
    output logic [NUM_KEYS-1:0] out,
    output logic                cmd_err,
    output logic [3:0]          leds
);

    localparam int SR_BITS = KEY_BITS + VEL_BITS;
    localparam logic [VEL_BITS-1:0] PHASE_LAST = VEL_BITS'((2 ** VEL_BITS) - 2);
    localparam logic [KEY_BITS:0]   KEY_LIMIT  = (KEY_BITS + 1)'(NUM_KEYS);

    if (SYNC_STAGES < 2 || HOLD_PERIODS < 1 || HOLD_DUTY >= (2 ** VEL_BITS) - 1) begin : g_param_check
        $error("key_pwm_ctrl: invalid parameter set");
    end

    // Host link synchronisers; edges are taken from the last two stages of each chain.
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] d_sync_reg;
    logic [SYNC_STAGES-1:0] latch_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_reg   <= '0;
            d_sync_reg     <= '0;
            latch_sync_reg <= '0;
        end else begin
            clk_sync_reg   <= {clk_sync_reg[SYNC_STAGES-2:0], sr_clk};
            d_sync_reg     <= {d_sync_reg[SYNC_STAGES-2:0], sr_d};
            latch_sync_reg <= {latch_sync_reg[SYNC_STAGES-2:0], sr_latch};
        end
    end

    logic sr_clk_rise;
    logic latch_rise;
    logic d_synced;
    logic latch_synced;

    assign sr_clk_rise  = clk_sync_reg[SYNC_STAGES-2] & ~clk_sync_reg[SYNC_STAGES-1];
    assign latch_rise   = latch_sync_reg[SYNC_STAGES-2] & ~latch_sync_reg[SYNC_STAGES-1];
    assign d_synced     = d_sync_reg[SYNC_STAGES-1];
    assign latch_synced = latch_sync_reg[SYNC_STAGES-1];

    logic [SR_BITS-1:0] sr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg <= '0;
        end else if (sr_clk_rise) begin
            sr_reg <= {sr_reg[SR_BITS-2:0], d_synced};
        end
    end

    logic [KEY_BITS-1:0] cmd_key;
    logic [VEL_BITS-1:0] cmd_vel;
    logic                key_valid;
    logic                wr_en;

    assign cmd_key   = sr_reg[SR_BITS-1 -: KEY_BITS];
    assign cmd_vel   = sr_reg[VEL_BITS-1:0];
    assign key_valid = {1'b0, cmd_key} < KEY_LIMIT;
    assign wr_en     = latch_rise & key_valid;

    logic                cmd_err_reg;
    logic [VEL_BITS-1:0] phase_reg;
    logic                boundary;
    logic                tgl_reg;

    assign boundary = (phase_reg == PHASE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err_reg <= 1'b0;
            phase_reg   <= '0;
            tgl_reg     <= 1'b0;
        end else begin
            cmd_err_reg <= latch_rise & ~key_valid;
            if (boundary) begin
                phase_reg <= '0;
                tgl_reg   <= ~tgl_reg;
            end else begin
                phase_reg <= phase_reg + VEL_BITS'(1);
            end
        end
    end

`ifdef KEY_HOLD_REDUCE_EN
    localparam int HC_W = $clog2(HOLD_PERIODS + 1);
    localparam logic [HC_W-1:0]     HOLD_MAX    = HC_W'(HOLD_PERIODS);
    localparam logic [HC_W-1:0]     HOLD_PRE    = HC_W'(HOLD_PERIODS - 1);
    localparam logic [VEL_BITS-1:0] HOLD_DUTY_V = VEL_BITS'(HOLD_DUTY);
`endif

    logic [NUM_KEYS-1:0] out_reg;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        logic                wr_hit;
        logic [VEL_BITS-1:0] shadow_reg;
        logic [VEL_BITS-1:0] shadow_fwd;
        logic [VEL_BITS-1:0] active_reg;
        logic [VEL_BITS-1:0] active_next;
        logic                drive_reg;

        assign wr_hit     = wr_en && (cmd_key == KEY_BITS'(gi));
        // A write landing in the boundary cycle bypasses the shadow so it is not a period late.
        assign shadow_fwd = wr_hit ? cmd_vel : shadow_reg;

`ifdef KEY_HOLD_REDUCE_EN
        logic [HC_W-1:0] hold_cnt_reg;
        logic            cnt_inc;
        logic            reduce;

        assign cnt_inc     = boundary && (active_reg > HOLD_DUTY_V) && (hold_cnt_reg != HOLD_MAX);
        // Drop to the hold duty on the same boundary the count reaches the limit; a fresh command overrides.
        assign reduce      = !wr_hit && ((hold_cnt_reg == HOLD_MAX) || (cnt_inc && hold_cnt_reg == HOLD_PRE));
        assign active_next = reduce ? HOLD_DUTY_V : shadow_fwd;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt_reg <= '0;
            end else if (wr_hit) begin
                hold_cnt_reg <= '0;
            end else if (cnt_inc) begin
                hold_cnt_reg <= hold_cnt_reg + HC_W'(1);
            end
        end
`else
        assign active_next = shadow_fwd;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_reg <= '0;
                active_reg <= '0;
                drive_reg  <= 1'b1;
            end else begin
                if (wr_hit) begin
                    shadow_reg <= cmd_vel;
                end
                if (boundary) begin
                    active_reg <= active_next;
                end
                drive_reg <= ~(phase_reg < active_reg);
            end
        end

        assign out_reg[gi] = drive_reg;
    end

    logic any_on_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_on_reg <= 1'b0;
        end else begin
            any_on_reg <= ~&out_reg;
        end
    end

    assign out     = out_reg;
    assign cmd_err = cmd_err_reg;
    assign leds    = {tgl_reg, latch_synced, d_synced, any_on_reg};

endmodule

// File: tb/tb_key_pwm_ctrl.sv
// Self-checking bench for key_pwm_ctrl: directed and random serial commands, duty measured as
// low-cycle counts per PWM period against a per-key duty model.
module tb_key_pwm_ctrl;

    localparam int NK = 12;
    localparam int P  = 127;
`ifdef KEY_HOLD_REDUCE_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sr_clk = 1'b0;
    logic          sr_d = 1'b0;
    logic          sr_latch = 1'b0;
    logic [NK-1:0] out;
    logic          cmd_err;
    logic [3:0]    leds;

    always #5 clk = ~clk;

    key_pwm_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sr_clk   (sr_clk),
        .sr_d     (sr_d),
        .sr_latch (sr_latch),
        .out      (out),
        .cmd_err  (cmd_err),
        .leds     (leds)
    );

    int checks = 0;
    int failures = 0;
    int err_cycles = 0;
    int lows [NK];
    int model_duty [NK];

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_boundary();
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = leds[3];
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (leds[3] !== prev) begin
                found = 1'b1;
                break;
            end
        end
        chk("boundary_seen", 32'(found), 32'd1);
    endtask

    // Any P consecutive cycles at a stable duty contain exactly 'duty' low cycles.
    task automatic measure_period();
        for (int k = 0; k < NK; k++) lows[k] = 0;
        repeat (P) begin
            @(negedge clk);
            for (int k = 0; k < NK; k++) if (out[k] === 1'b0) lows[k]++;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NK; k++)
            chk($sformatf("%s_key%0d", tag, k), 32'(lows[k]), 32'(model_duty[k]));
    endtask

    task automatic send_bits(input int key, input int vel);
        logic [13:0] w;
        w = {key[6:0], vel[6:0]};
        for (int i = 13; i >= 0; i--) begin
            sr_d = w[i];
            repeat (6) @(negedge clk);
            sr_clk = 1'b1;
            repeat (6) @(negedge clk);
            sr_clk = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("leds1_synced_d", 32'(leds[1]), 32'(vel & 1));
    endtask

    // Latch just after a boundary so the commit is well clear of the next one.
    task automatic send_cmd(input string tag, input int key, input int vel);
        int base;
        base = err_cycles;
        send_bits(key, vel);
        wait_boundary();
        sr_latch = 1'b1;
        repeat (6) @(negedge clk);
        sr_latch = 1'b0;
        repeat (4) @(negedge clk);
        chk($sformatf("%s_err_cycles", tag), 32'(err_cycles - base), (key >= NK) ? 32'd1 : 32'd0);
        if (key < NK) model_duty[key] = vel;
        wait_boundary();
        measure_period();
        check_all(tag);
        $display("cmd %s key=%0d vel=%0d lows[key%%12]=%0d", tag, key, vel, lows[key % NK]);
    endtask

    task automatic do_reset(input string tag);
        int n;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_out"}, 32'(out), 32'hFFF);
        chk({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
        chk({tag, "_leds"}, 32'(leds), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NK; k++) model_duty[k] = 0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (leds[3] === 1'b1) begin
                n = i;
                break;
            end
        end
        chk({tag, "_phase_restart"}, 32'(n), 32'(P));
        measure_period();
        check_all({tag, "_duty"});
        chk({tag, "_leds0_off"}, 32'(leds[0]), 32'd0);
        $display("reset %s first boundary after %0d cycles", tag, n);
    endtask

    initial begin
        int base;
        int expd;
        for (int k = 0; k < NK; k++) model_duty[k] = 0;

        do_reset("rst0");

        send_cmd("k3_v64", 3, 64);
        send_cmd("k0_v127", 0, 127);
        chk("leds0_any_on", 32'(leds[0]), 32'd1);
        send_cmd("k0_v0", 0, 0);
        send_cmd("k12_err", 12, 50);

        // Reset mid-period with keys on.
        send_cmd("k0_v127b", 0, 127);
        repeat (40) @(negedge clk);
        do_reset("rst_mid");

        // Commit in the boundary cycle must be forwarded into the very next period.
        send_cmd("k5_v90", 5, 90);
        base = err_cycles;
        send_bits(5, 10);
        wait_boundary();
        repeat (P - 2) @(negedge clk);
        sr_latch = 1'b1;
        wait_boundary();
        sr_latch = 1'b0;
        model_duty[5] = 10;
        measure_period();
        check_all("fwd");
        chk("fwd_err_cycles", 32'(err_cycles - base), 32'd0);
        $display("fwd key=5 vel=10 lows=%0d", lows[5]);

        do_reset("rst_rand");
        for (int i = 0; i < 8; i++) begin
            send_cmd($sformatf("rand%0d", i), int'($urandom_range(0, 15)), int'($urandom_range(0, 127)));
        end

        // Hold reduction: periods 1..64 at the commanded duty, then the hold duty.
        do_reset("rst_hold");
        for (int pass = 0; pass < 2; pass++) begin
            send_cmd($sformatf("hold%0d", pass), 2, 100);
            for (int p = 2; p <= 67; p++) begin
                measure_period();
                expd = (HOLD_EN && p > 64) ? 32 : 100;
                chk($sformatf("hold%0d_p%0d", pass, p), 32'(lows[2]), 32'(expd));
            end
            $display("hold pass %0d last period lows=%0d", pass, lows[2]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
